// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the ALU control sequencer: ALUOp classes, funct codes,
// ALU op codes and the mult/div sequencer states.
package alu_ctrl_pkg;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_RSVD  = 2'b11;

    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_ADDU  = 6'b100001;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_SUBU  = 6'b100011;
    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_XOR   = 6'b100110;
    localparam logic [5:0] F_NOR   = 6'b100111;
    localparam logic [5:0] F_SLT   = 6'b101010;
    localparam logic [5:0] F_SLTU  = 6'b101011;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;

    // Op codes are 4 bits wide; wider OP_W outputs zero-extend them.
    localparam int         OP_MIN_W  = 4;
    localparam logic [3:0] OP_AND    = 4'b0000;
    localparam logic [3:0] OP_OR     = 4'b0001;
    localparam logic [3:0] OP_ADD    = 4'b0010;
    localparam logic [3:0] OP_XOR    = 4'b0011;
    localparam logic [3:0] OP_SUB    = 4'b0110;
    localparam logic [3:0] OP_SLT    = 4'b0111;
    localparam logic [3:0] OP_SLTU   = 4'b1000;
    localparam logic [3:0] OP_MULT   = 4'b1010;
    localparam logic [3:0] OP_DIV    = 4'b1011;
    localparam logic [3:0] OP_NOR    = 4'b1100;
    localparam logic [3:0] OP_MFHILO = 4'b1101;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MD_RUN  = 2'd1,
        MD_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_funct_decode.sv
// Combinational ALUOp/funct decoder producing the ALU op code plus the
// side-band flags the sequencer needs (illegal, mult/div class, signedness, HI/LO select).
module alu_funct_decode
    import alu_ctrl_pkg::*;
#(
    parameter int FUNCT_W       = 6,
    parameter int ENABLE_MULDIV = 1
) (
    input  logic [FUNCT_W-1:0] instruction_i,
    input  logic [1:0]         alu_op_i,
    output logic [3:0]         op_o,
    output logic               illegal_o,
    output logic               is_md_o,
    output logic               md_signed_o,
    output logic               hilo_sel_o
);

    localparam bit MD_EN = (ENABLE_MULDIV != 0);

    always_comb begin
        op_o        = OP_AND;
        illegal_o   = 1'b0;
        is_md_o     = 1'b0;
        md_signed_o = 1'b0;
        hilo_sel_o  = 1'b0;
        case (alu_op_i)
            ALUOP_ADD: op_o = OP_ADD;
            ALUOP_SUB: op_o = OP_SUB;
            ALUOP_RTYPE: begin
                // Non-zero bits above the 6-bit funct fall through to illegal.
                case (instruction_i)
                    FUNCT_W'(F_ADD), FUNCT_W'(F_ADDU): op_o = OP_ADD;
                    FUNCT_W'(F_SUB), FUNCT_W'(F_SUBU): op_o = OP_SUB;
                    FUNCT_W'(F_AND):  op_o = OP_AND;
                    FUNCT_W'(F_OR):   op_o = OP_OR;
                    FUNCT_W'(F_XOR):  op_o = OP_XOR;
                    FUNCT_W'(F_NOR):  op_o = OP_NOR;
                    FUNCT_W'(F_SLT):  op_o = OP_SLT;
                    FUNCT_W'(F_SLTU): op_o = OP_SLTU;
                    FUNCT_W'(F_MFHI), FUNCT_W'(F_MFLO): begin
                        if (MD_EN) begin
                            op_o       = OP_MFHILO;
                            hilo_sel_o = (instruction_i == FUNCT_W'(F_MFHI));
                        end else begin
                            illegal_o = 1'b1;
                        end
                    end
                    FUNCT_W'(F_MULT), FUNCT_W'(F_MULTU),
                    FUNCT_W'(F_DIV),  FUNCT_W'(F_DIVU): begin
                        if (MD_EN) begin
                            op_o        = instruction_i[1] ? OP_DIV : OP_MULT;
                            is_md_o     = 1'b1;
                            md_signed_o = ~instruction_i[0];
                        end else begin
                            illegal_o = 1'b1;
                        end
                    end
                    default: illegal_o = 1'b1;
                endcase
            end
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_control_seq.sv
// ALU control with valid/ready handshake and a multi-cycle mult/div sequencer
// that stalls the datapath and commits HI/LO once the iterations complete.
module alu_control_seq
    import alu_ctrl_pkg::*;
#(
    parameter int FUNCT_W       = 6,
    parameter int OP_W          = 4,
    parameter int MD_CYCLES     = 32,
    parameter int CNT_W         = $clog2(MD_CYCLES + 1),
    parameter int ENABLE_MULDIV = 1
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic [FUNCT_W-1:0] instruction,
    input  logic [1:0]         ALUOp,
    input  logic               valid_in,
    input  logic               flush,
    output logic               in_ready,
    output logic [OP_W-1:0]    op,
    output logic               op_valid,
    output logic               illegal,
    output logic               busy,
    output logic               md_start,
    output logic               md_step,
    output logic               md_signed,
    output logic               md_done,
    output logic               hilo_we,
    output logic               hilo_sel
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MD_CYCLES - 1);

    logic [3:0] dec_op;
    logic       dec_illegal;
    logic       dec_is_md;
    logic       dec_md_signed;
    logic       dec_hilo_sel;

    alu_funct_decode #(
        .FUNCT_W      (FUNCT_W),
        .ENABLE_MULDIV(ENABLE_MULDIV)
    ) u_decode (
        .instruction_i(instruction),
        .alu_op_i     (ALUOp),
        .op_o         (dec_op),
        .illegal_o    (dec_illegal),
        .is_md_o      (dec_is_md),
        .md_signed_o  (dec_md_signed),
        .hilo_sel_o   (dec_hilo_sel)
    );

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic [OP_W-1:0]   op_q;
    logic              op_valid_q;
    logic              illegal_q;
    logic              busy_q;
    logic              md_start_q;
    logic              md_step_q;
    logic              md_signed_q;
    logic              md_done_q;
    logic              hilo_sel_q;
    logic              accept;

    assign in_ready = (state_q == IDLE);
    assign accept   = valid_in && in_ready && !flush;
    assign cnt_d    = cnt_q + 1'b1;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            op_q        <= '0;
            op_valid_q  <= 1'b0;
            illegal_q   <= 1'b0;
            busy_q      <= 1'b0;
            md_start_q  <= 1'b0;
            md_step_q   <= 1'b0;
            md_signed_q <= 1'b0;
            md_done_q   <= 1'b0;
            hilo_sel_q  <= 1'b0;
        end else begin
            op_valid_q <= 1'b0;
            illegal_q  <= 1'b0;
            md_start_q <= 1'b0;
            md_done_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        op_q       <= OP_W'(dec_op);
                        op_valid_q <= 1'b1;
                        illegal_q  <= dec_illegal;
                        hilo_sel_q <= dec_hilo_sel;
                        if (dec_is_md) begin
                            state_q     <= MD_RUN;
                            cnt_q       <= '0;
                            md_signed_q <= dec_md_signed;
                            md_start_q  <= 1'b1;
                            md_step_q   <= 1'b1;
                            busy_q      <= 1'b1;
                        end
                    end
                end
                MD_RUN: begin
                    // A flush on any step, the last included, drops the result.
                    if (flush) begin
                        state_q   <= IDLE;
                        cnt_q     <= '0;
                        md_step_q <= 1'b0;
                        busy_q    <= 1'b0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q   <= MD_DONE;
                        cnt_q     <= '0;
                        md_step_q <= 1'b0;
                        md_done_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                MD_DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign op        = op_q;
    assign op_valid  = op_valid_q;
    assign illegal   = illegal_q;
    assign busy      = busy_q;
    assign md_start  = md_start_q;
    assign md_step   = md_step_q;
    assign md_signed = md_signed_q;
    assign md_done   = md_done_q;
    assign hilo_we   = md_done_q;
    assign hilo_sel  = hilo_sel_q;

endmodule

// File: tb/tb_alu_control_seq.sv
// Directed plus randomized bench for alu_control_seq against a timeline model;
// a second instance with mult/div disabled is checked alongside.
module tb_alu_control_seq;

    localparam int M = 4;

    logic       Clk = 1'b0;
    logic       Rst = 1'b0;
    logic [5:0] instruction = '0;
    logic [1:0] ALUOp = '0;
    logic       valid_in = 1'b0;
    logic       flush = 1'b0;

    logic       in_ready, op_valid, illegal, busy, md_start, md_step;
    logic       md_signed, md_done, hilo_we, hilo_sel;
    logic [3:0] op;

    logic       in_ready2, op_valid2, illegal2, busy2, md_start2, md_step2;
    logic       md_signed2, md_done2, hilo_we2, hilo_sel2;
    logic [3:0] op2;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 Clk = ~Clk;

    alu_control_seq #(.FUNCT_W(6), .OP_W(4), .MD_CYCLES(M), .ENABLE_MULDIV(1)) u_dut (
        .Clk(Clk), .Rst(Rst), .instruction(instruction), .ALUOp(ALUOp),
        .valid_in(valid_in), .flush(flush), .in_ready(in_ready), .op(op),
        .op_valid(op_valid), .illegal(illegal), .busy(busy), .md_start(md_start),
        .md_step(md_step), .md_signed(md_signed), .md_done(md_done),
        .hilo_we(hilo_we), .hilo_sel(hilo_sel)
    );

    alu_control_seq #(.FUNCT_W(6), .OP_W(4), .MD_CYCLES(M), .ENABLE_MULDIV(0)) u_dut_nomd (
        .Clk(Clk), .Rst(Rst), .instruction(instruction), .ALUOp(ALUOp),
        .valid_in(valid_in), .flush(flush), .in_ready(in_ready2), .op(op2),
        .op_valid(op_valid2), .illegal(illegal2), .busy(busy2), .md_start(md_start2),
        .md_step(md_step2), .md_signed(md_signed2), .md_done(md_done2),
        .hilo_we(hilo_we2), .hilo_sel(hilo_sel2)
    );

    typedef struct {
        logic [3:0] op;
        logic       ill;
        logic       md;
        logic       sg;
        logic       hs;
    } dec_t;

    // Reference behaviour: cycles elapsed since a mult/div was accepted
    // (0 = idle, 1..M = iterating, M+1 = writeback cycle).
    int         ph = 0;
    logic [3:0] m_op = 4'h0;
    logic       m_sg = 1'b0;
    logic       m_hs = 1'b0;
    logic [3:0] m2_op = 4'h0;

    function automatic dec_t ref_decode(input logic [1:0] a, input logic [5:0] f, input bit en);
        dec_t d;
        d = '{op: 4'h0, ill: 1'b0, md: 1'b0, sg: 1'b0, hs: 1'b0};
        if (a == 2'b00) d.op = 4'h2;
        else if (a == 2'b01) d.op = 4'h6;
        else if (a == 2'b11) d.ill = 1'b1;
        else begin
            case (f)
                6'h20, 6'h21: d.op = 4'h2;
                6'h22, 6'h23: d.op = 4'h6;
                6'h24: d.op = 4'h0;
                6'h25: d.op = 4'h1;
                6'h26: d.op = 4'h3;
                6'h27: d.op = 4'hC;
                6'h2A: d.op = 4'h7;
                6'h2B: d.op = 4'h8;
                6'h10: if (en) begin d.op = 4'hD; d.hs = 1'b1; end else d.ill = 1'b1;
                6'h12: if (en) d.op = 4'hD; else d.ill = 1'b1;
                6'h18, 6'h19, 6'h1A, 6'h1B: begin
                    if (en) begin
                        d.op = (f >= 6'h1A) ? 4'hB : 4'hA;
                        d.md = 1'b1;
                        d.sg = (f == 6'h18) || (f == 6'h1A);
                    end else d.ill = 1'b1;
                end
                default: d.ill = 1'b1;
            endcase
        end
        return d;
    endfunction

    task automatic expect_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic do_cycle(input logic v, input logic [1:0] a, input logic [5:0] f, input logic fl);
        dec_t d, d2;
        logic acc, acc2, e_ov, e_ill, e_start;
        logic e_ov2, e_ill2;
        @(negedge Clk);
        valid_in = v; ALUOp = a; instruction = f; flush = fl;
        #1;
        expect_eq("in_ready_pre", in_ready, ph == 0);
        d = ref_decode(a, f, 1'b1);
        d2 = ref_decode(a, f, 1'b0);
        acc = v && !fl && (ph == 0);
        e_ov = 1'b0; e_ill = 1'b0; e_start = 1'b0;
        if (ph == 0) begin
            if (acc) begin
                m_op = d.op; e_ov = 1'b1; e_ill = d.ill; m_hs = d.hs;
                if (d.md) begin ph = 1; m_sg = d.sg; e_start = 1'b1; end
            end
        end else if (ph <= M) begin
            if (fl) ph = 0;
            else ph = ph + 1;
        end else begin
            ph = 0;
        end
        acc2 = v && !fl;
        e_ov2 = acc2; e_ill2 = acc2 && d2.ill;
        if (acc2) m2_op = d2.op;
        @(posedge Clk);
        #1;
        expect_eq("op", op, m_op);
        expect_eq("op_valid", op_valid, e_ov);
        expect_eq("illegal", illegal, e_ill);
        expect_eq("md_start", md_start, e_start);
        expect_eq("md_step", md_step, (ph >= 1) && (ph <= M));
        expect_eq("md_done", md_done, ph == M + 1);
        expect_eq("hilo_we", hilo_we, ph == M + 1);
        expect_eq("busy", busy, ph != 0);
        expect_eq("in_ready", in_ready, ph == 0);
        if (ph != 0) expect_eq("md_signed", md_signed, m_sg);
        if (m_op == 4'hD) expect_eq("hilo_sel", hilo_sel, m_hs);
        expect_eq("nomd_op", op2, m2_op);
        expect_eq("nomd_op_valid", op_valid2, e_ov2);
        expect_eq("nomd_illegal", illegal2, e_ill2);
        expect_eq("nomd_busy", busy2, 1'b0);
        expect_eq("nomd_in_ready", in_ready2, 1'b1);
        expect_eq("nomd_hilo_we", hilo_we2, 1'b0);
    endtask

    task automatic check_reset_outputs();
        expect_eq("rst_op", op, 4'h0);
        expect_eq("rst_op_valid", op_valid, 1'b0);
        expect_eq("rst_illegal", illegal, 1'b0);
        expect_eq("rst_busy", busy, 1'b0);
        expect_eq("rst_md_start", md_start, 1'b0);
        expect_eq("rst_md_step", md_step, 1'b0);
        expect_eq("rst_md_signed", md_signed, 1'b0);
        expect_eq("rst_md_done", md_done, 1'b0);
        expect_eq("rst_hilo_we", hilo_we, 1'b0);
        expect_eq("rst_hilo_sel", hilo_sel, 1'b0);
        expect_eq("rst_in_ready", in_ready, 1'b1);
        expect_eq("rst_nomd_op", op2, 4'h0);
    endtask

    task automatic async_reset();
        @(negedge Clk);
        valid_in = 1'b0; flush = 1'b0;
        #2 Rst = 1'b0;
        #1 check_reset_outputs();
        ph = 0; m_op = 4'h0; m_sg = 1'b0; m_hs = 1'b0; m2_op = 4'h0;
        @(negedge Clk);
        Rst = 1'b1;
    endtask

    logic [5:0] funct_pool [0:15];

    initial begin
        funct_pool = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                       6'h2A, 6'h2B, 6'h10, 6'h12, 6'h18, 6'h19, 6'h1A, 6'h1B};
        #3 check_reset_outputs();
        @(negedge Clk);
        @(negedge Clk);
        Rst = 1'b1;

        do_cycle(1'b1, 2'b10, 6'h20, 1'b0);
        do_cycle(1'b0, 2'b10, 6'h20, 1'b0);
        // add accepted, then reset while a mult is iterating
        do_cycle(1'b1, 2'b10, 6'h18, 1'b0);
        do_cycle(1'b0, 2'b10, 6'h00, 1'b0);
        async_reset();

        do_cycle(1'b1, 2'b10, 6'h26, 1'b0);
        do_cycle(1'b1, 2'b10, 6'h27, 1'b0);
        do_cycle(1'b1, 2'b10, 6'h2B, 1'b0);
        do_cycle(1'b1, 2'b10, 6'h2A, 1'b0);

        do_cycle(1'b1, 2'b10, 6'h18, 1'b0);
        for (int i = 0; i < M + 3; i++) do_cycle(1'b1, 2'b10, 6'h26, 1'b0);

        do_cycle(1'b1, 2'b10, 6'h1B, 1'b0);
        for (int i = 0; i < M - 1; i++) do_cycle(1'b0, 2'b10, 6'h00, 1'b0);
        do_cycle(1'b0, 2'b10, 6'h00, 1'b1);
        do_cycle(1'b1, 2'b10, 6'h1A, 1'b0);
        for (int i = 0; i < M + 2; i++) do_cycle(1'b0, 2'b10, 6'h00, 1'b0);

        do_cycle(1'b1, 2'b10, 6'h3F, 1'b0);
        do_cycle(1'b1, 2'b11, 6'h20, 1'b0);
        do_cycle(1'b1, 2'b10, 6'h10, 1'b0);
        do_cycle(1'b1, 2'b10, 6'h12, 1'b0);
        do_cycle(1'b1, 2'b10, 6'h20, 1'b1);
        do_cycle(1'b1, 2'b00, 6'h00, 1'b0);
        do_cycle(1'b1, 2'b01, 6'h00, 1'b0);

        for (int i = 0; i < 1500; i++) begin
            logic       rv, rfl;
            logic [1:0] ra;
            logic [5:0] rf;
            rv  = ($urandom_range(0, 9) < 6);
            rfl = ($urandom_range(0, 19) == 0);
            ra  = ($urandom_range(0, 9) < 7) ? 2'b10 : 2'($urandom_range(0, 3));
            rf  = ($urandom_range(0, 9) < 8) ? funct_pool[$urandom_range(0, 15)]
                                              : 6'($urandom_range(0, 63));
            do_cycle(rv, ra, rf, rfl);
            if (i == 700) async_reset();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
